// File: rtl/data_regfile_pkg.sv
// Shared types and the address decode helper for the data register file.
// Decode arithmetic is done in 33 bits so out-of-range addresses never alias back onto a valid word.
package data_regfile_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    localparam int DEF_DATA_WIDTH = 80;
    localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] index;
    } addr_dec_t;

    // Stride is a power of two, so the divide/modulo fold to shifts/masks once parameters are fixed.
    function automatic addr_dec_t addr_to_index(input logic [32:0] addr,
                                                input logic [32:0] base,
                                                input logic [32:0] stride,
                                                input logic [32:0] num_words);
        addr_dec_t   res;
        logic [32:0] off;
        logic [32:0] idx;
        off       = addr - base;
        idx       = off / stride;
        res.valid = (addr >= base) && ((off % stride) == '0) && (idx < num_words);
        res.index = idx[31:0];
        return res;
    endfunction

endpackage

// File: rtl/regfile_addr_decode.sv
// Combinational address-to-word-index decode; one instance per access port.
module regfile_addr_decode
    import data_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_WORDS   = 4,
    parameter int ADDR_STRIDE = 4,
    parameter int BASE_ADDR   = 0,
    parameter int IDX_W       = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  valid,
    output logic [IDX_W-1:0]      index
);

    addr_dec_t         dec;
    logic [31-IDX_W:0] unused_idx_hi;

    always_comb begin
        dec = addr_to_index(33'(addr), 33'(BASE_ADDR), 33'(ADDR_STRIDE), 33'(NUM_WORDS));
    end

    assign valid         = dec.valid;
    assign index         = dec.index[IDX_W-1:0];
    assign unused_idx_hi = dec.index[31:IDX_W];

endmodule

// File: rtl/data_regfile.sv
// Parametrised register file with byte-enabled writes, ack/err handshakes and a sequenced bulk clear.
module data_regfile
    import data_regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 80,
    parameter int                    NUM_WORDS   = 4,
    parameter int                    ADDR_STRIDE = 4,
    parameter int                    BASE_ADDR   = 0,
    parameter logic [DATA_WIDTH-1:0] RD_DEFAULT  = 'hDEADDEAD
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    wr_ack,
    output logic                    wr_err,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_err,
    input  logic                    clr_req,
    output logic                    busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(NUM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    clr_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic                  wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
    logic                  rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic             wr_ok, rd_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    regfile_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS), .ADDR_STRIDE(ADDR_STRIDE),
                          .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W))
        u_wr_dec (.addr(wr_addr), .valid(wr_ok), .index(wr_idx));

    regfile_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_WORDS), .ADDR_STRIDE(ADDR_STRIDE),
                          .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W))
        u_rd_dec (.addr(rd_addr), .valid(rd_ok), .index(rd_idx));

    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_ack_d   = wr_req;
        wr_err_d   = wr_req && (!wr_ok || busy_q);
        rd_valid_d = rd_req;
        rd_err_d   = rd_req && (!rd_ok || busy_q);
        rd_data_d  = rd_data_q;

        if (wr_req && wr_ok && !busy_q) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        // mem_q is the pre-edge value, giving read-old on a same-cycle write.
        if (rd_req) rd_data_d = (rd_ok && !busy_q) ? mem_q[rd_idx] : RD_DEFAULT;

        // Writes are blocked while busy, so the clear never races a real write.
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(NUM_WORDS - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
            state_q    <= IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_data_regfile.sv
// Directed plus randomized checks of data_regfile against an array-based reference model.
module tb_data_regfile;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        wr_req, rd_req, clr_req;
    logic [7:0]  wr_addr, rd_addr;
    logic [79:0] wr_data;
    logic [9:0]  wr_be;
    logic        wr_ack, wr_err, rd_valid, rd_err, busy;
    logic [79:0] rd_data;

    localparam logic [79:0] DEAD = 80'hDEADDEAD;

    logic [79:0] ref_mem [4];
    logic [79:0] last_rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    data_regfile dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit addr_ok(input logic [7:0] a);
        return (a % 4 == 0) && (a / 4 < 4);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One non-busy cycle with optional write and read; checks the following cycle's outputs.
    task automatic cyc(input bit w, input logic [7:0] wa, input logic [79:0] wd, input logic [9:0] wb,
                       input bit r, input logic [7:0] ra);
        logic [79:0] exp_rd;
        wr_req = w; wr_addr = wa; wr_data = wd; wr_be = wb;
        rd_req = r; rd_addr = ra;
        exp_rd = last_rd;
        if (r) exp_rd = addr_ok(ra) ? ref_mem[ra / 4] : DEAD;
        if (w && addr_ok(wa))
            for (int b = 0; b < 10; b++) if (wb[b]) ref_mem[wa / 4][8*b +: 8] = wd[8*b +: 8];
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("wr_ack", 80'(wr_ack), 80'(w));
        if (w) chk("wr_err", 80'(wr_err), 80'(!addr_ok(wa)));
        chk("rd_valid", 80'(rd_valid), 80'(r));
        if (r) chk("rd_err", 80'(rd_err), 80'(!addr_ok(ra)));
        chk("rd_data", rd_data, exp_rd);
        chk("busy_idle", 80'(busy), 80'(0));
        last_rd = exp_rd;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 8'(i * 4), 80'({$urandom(), $urandom(), $urandom()}), 10'h3FF, 1'b0, 8'h00);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'(i * 4));
            chk("cleared_word", rd_data, 80'h0);
        end
    endtask

    initial begin
        rst_n_in = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        last_rd = '0;
        #12;
        chk("rst_wr_ack", 80'(wr_ack), 80'(0));
        chk("rst_rd_valid", 80'(rd_valid), 80'(0));
        chk("rst_rd_data", rd_data, 80'h0);
        chk("rst_busy", 80'(busy), 80'(0));
        step();
        rst_n_in = 1'b1;
        step();

        // Directed cases
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'h00);
        cyc(1'b1, 8'h04, 80'h1122_3344_5566_7788_99AA, 10'h3FF, 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'h04);
        chk("word1_value", rd_data, 80'h1122_3344_5566_7788_99AA);
        cyc(1'b1, 8'h08, {80{1'b1}}, 10'h3FF, 1'b0, 8'h00);
        cyc(1'b1, 8'h08, 80'h0, 10'h001, 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'h08);
        chk("byte_enable", rd_data, 80'hFFFF_FFFF_FFFF_FFFF_FF00);
        cyc(1'b1, 8'h08, 80'h0, 10'h000, 1'b0, 8'h00);
        cyc(1'b1, 8'h02, 80'h5, 10'h3FF, 1'b1, 8'h02);
        cyc(1'b1, 8'h10, 80'h5, 10'h3FF, 1'b1, 8'h10);
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'hFC);
        cyc(1'b1, 8'h0C, 80'h3, 10'h3FF, 1'b0, 8'h00);
        cyc(1'b1, 8'h0C, 80'h5, 10'h3FF, 1'b1, 8'h0C);
        chk("read_old", rd_data, 80'h3);
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'h0C);
        chk("read_new", rd_data, 80'h5);

        // Randomized mix of reads/writes, valid and invalid addresses
        for (int n = 0; n < 60; n++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)),
                80'({$urandom(), $urandom(), $urandom()}), 10'($urandom()),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)));

        // Bulk clear: busy exactly four cycles, requests rejected while busy
        fill_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("busy_c1", 80'(busy), 80'(1));
        wr_req = 1'b1; wr_addr = 8'h00; wr_data = 80'h77; wr_be = 10'h3FF;
        rd_req = 1'b1; rd_addr = 8'h04;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        chk("busy_c2", 80'(busy), 80'(1));
        chk("busy_wr_ack", 80'(wr_ack), 80'(1));
        chk("busy_wr_err", 80'(wr_err), 80'(1));
        chk("busy_rd_valid", 80'(rd_valid), 80'(1));
        chk("busy_rd_err", 80'(rd_err), 80'(1));
        chk("busy_rd_data", rd_data, DEAD);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("busy_c3", 80'(busy), 80'(1));
        step();
        chk("busy_c4", 80'(busy), 80'(1));
        step();
        chk("busy_done", 80'(busy), 80'(0));
        step();
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        last_rd = DEAD;
        read_all_zero();

        // Reset during the second clear cycle
        fill_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        chk("busy_before_rst", 80'(busy), 80'(1));
        rst_n_in = 1'b0;
        #1;
        chk("busy_async_rst", 80'(busy), 80'(0));
        chk("rd_data_async_rst", rd_data, 80'h0);
        step();
        rst_n_in = 1'b1;
        step();
        chk("busy_after_rst", 80'(busy), 80'(0));
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        last_rd = '0;
        read_all_zero();
        cyc(1'b1, 8'h04, 80'hABCD, 10'h3FF, 1'b1, 8'h04);
        cyc(1'b0, 8'h00, 80'h0, 10'h0, 1'b1, 8'h04);
        chk("idle_after_rst", rd_data, 80'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_regfile.md
Name: data_regfile

Overview:
Parametrised successor to the fixed four-word data store: a register file of NUM_WORDS words of DATA_WIDTH bits, decoded on a configurable base address and stride.
- Adds byte-enabled writes, request/ack handshakes with error reporting, and a sequenced bulk-clear engine with busy indication.
- Sits between the transceiver's framing/control logic and its payload datapath; holds outgoing and received frame words.

Parameters:
ADDR_WIDTH, 8, width of wr_addr/rd_addr
DATA_WIDTH, 80, word width in bits; must be a multiple of 8
NUM_WORDS, 4, number of storage words; >= 2
ADDR_STRIDE, 4, address step between words; power of two, >= 1
BASE_ADDR, 0, address of word 0
RD_DEFAULT, 'hDEADDEAD, rd_data value on error, zero-extended to DATA_WIDTH

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous, active-low reset
wr_req  input  1  write request, single-cycle qualifier
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_be  input  DATA_WIDTH/8  byte enables; bit i gates byte [8i+7:8i]
wr_ack  output  1  one-cycle pulse, write completed or rejected
wr_err  output  1  valid with wr_ack; 1 = bad address or busy
rd_req  input  1  read request, single-cycle qualifier
rd_addr  input  ADDR_WIDTH  read address
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_data  output  DATA_WIDTH  read data, held until next rd_valid
rd_err  output  1  valid with rd_valid; 1 = bad address or busy
clr_req  input  1  start bulk clear (pulse)
busy  output  1  clear engine active

Behaviour:
- Reset (async): all words = 0, rd_data = 0, wr_ack/wr_err/rd_valid/rd_err/busy = 0, FSM = IDLE.
- Address decode: valid iff addr >= BASE_ADDR, (addr-BASE_ADDR) mod ADDR_STRIDE == 0, and index = (addr-BASE_ADDR)/ADDR_STRIDE < NUM_WORDS. Arithmetic is in ADDR_WIDTH+1 bits; no wrap-around aliasing.
- Write: wr_req in cycle N with a valid address, not busy -> the enabled bytes are updated at the edge ending cycle N. wr_ack=1, wr_err=0 in cycle N+1. Bytes with wr_be=0 are unchanged; wr_be=0 gives an ack with no change.
- Write rejected (bad address or busy): no storage change; wr_ack=1, wr_err=1 in N+1.
- Read: rd_req in cycle N -> rd_valid=1 in N+1, rd_data = the word as it was before cycle N's edge (read-old on a same-cycle write to the same address), rd_err=0.
- Read rejected (bad address or busy): rd_valid=1, rd_err=1, rd_data=RD_DEFAULT in N+1.
- Reads and writes are independent; both may occur in the same cycle.
- Clear FSM states:
  - IDLE: clr_req -> CLEAR with ptr=0; busy=1 from the next cycle.
  - CLEAR: word[ptr]=0 each cycle, ptr++; on ptr==NUM_WORDS-1 -> DONE.
  - DONE: busy=0 this cycle, -> IDLE.
  - Total: busy high exactly NUM_WORDS cycles.
- clr_req while busy: ignored.
- A wr_req/rd_req in the same cycle as the accepted clr_req is served normally; requests are rejected only while busy=1.
- Reset mid-clear: immediate return to IDLE, all words 0.
- Simultaneous wr_req and the clear writing the same word: the clear wins; the write is rejected anyway because busy=1.

Decomposition:
- Package data_regfile_pkg: typedef clr_state_t (IDLE, CLEAR, DONE); function addr_to_index returning {valid, index}; localparam BE_WIDTH = DATA_WIDTH/8.
- Sub-module regfile_addr_decode: combinational decode, instantiated twice (write and read ports).
- Storage, handshake and FSM stay in the top module.

Test Plan:
- After reset, read 0x00 -> next cycle rd_valid=1, rd_err=0, rd_data=0.
- Write 0x04 data 80'h1122_3344_5566_7788_99AA, be=10'h3FF; then read 0x04 -> wr_ack=1/wr_err=0, then rd_data=80'h1122_3344_5566_7788_99AA.
- Byte enables: write 0x08 all-ones with be=3FF, then write 0x08 zero with be=10'h001; read 0x08 -> 80'hFFFF_FFFF_FFFF_FFFF_FF00.
- Bad addresses 0x02 (misaligned) and 0x10 (index 4): write -> wr_err=1, no change; read -> rd_err=1, rd_data=80'hDEADDEAD.
- Same-cycle write 0x0C=5 and read 0x0C (old value 3) -> rd_data=3; a read one cycle later -> 5.
- Fill all words, pulse clr_req -> busy high exactly 4 cycles; a read and a write issued while busy both return err=1. After busy falls, all reads return 0.
- Assert rst_n_in during the 2nd clear cycle -> busy=0 immediately, all words 0, FSM IDLE.
